// File: rtl/lfsr_pkg.sv
// lfsr_pkg -- shared constants and types for the lfsr block.
//   REG_W     : width of the scramble register
//   TAPS      : feedback tap mask for x^4+x^3+1 in right-shift Fibonacci form
//               (feedback bit = R[1] ^ R[0], entering at the MSB)
//   EXTRACT_N : number of register bits emitted serially after scrambling
//   phase_t   : decoded phase of the cycle counter
package lfsr_pkg;

  localparam int REG_W     = 4;
  localparam logic [REG_W-1:0] TAPS = 4'b0011;
  localparam int EXTRACT_N = 4;

  typedef enum logic [1:0] {
    PH_SCRAMBLE = 2'd0,
    PH_EXTRACT  = 2'd1,
    PH_IDLE     = 2'd2
  } phase_t;

endpackage

// File: rtl/lfsr.sv
// lfsr -- seeded 4-bit scrambler that emits its register serially, LSB first.
// After reset release the register is scrambled LFSR_CYCLES times, then its
// four bits are shifted out on OUT with Valid high, then the block idles.
//
// Parameters:
//   LFSR_CYCLES : scramble steps before output begins (1..14), default 8
// Ports:
//   clk   in  1  single clock, rising edge
//   rst   in  1  asynchronous active-low reset; loads R from Seed
//   Seed  in  4  initial register value, sampled only while rst is low
//   OUT   out 1  registered serial data bit
//   Valid out 1  registered, high while OUT carries an extracted bit
//
// Optional build macro:
//   LFSR_AUTO_RESTART_EN : after the fourth extracted bit, reload R from the
//                          current Seed and restart the sequence instead of
//                          idling until reset.
//
// Phase table (decoded from the cycle counter):
//   PH_SCRAMBLE | cnt <  LFSR_CYCLES      : one scramble step per edge
//   PH_EXTRACT  | cnt <  LFSR_CYCLES + 4  : shift R[0] out, zero fill
//   PH_IDLE     | cnt == LFSR_CYCLES + 4  : hold (or restart if enabled)
module lfsr
  import lfsr_pkg::*;
#(
  parameter int LFSR_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Seed,
  output logic             OUT,
  output logic             Valid
);

  localparam int CNT_W = $clog2(LFSR_CYCLES + EXTRACT_N + 1);
  localparam logic [CNT_W-1:0] SCR_END = CNT_W'(LFSR_CYCLES);
  localparam logic [CNT_W-1:0] EXT_END = CNT_W'(LFSR_CYCLES + EXTRACT_N);

  logic [REG_W-1:0] r, r_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, valid_nxt;
  phase_t           phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r     <= Seed;
      cnt   <= '0;
      OUT   <= 1'b0;
      Valid <= 1'b0;
    end else begin
      r     <= r_nxt;
      cnt   <= cnt_nxt;
      OUT   <= out_nxt;
      Valid <= valid_nxt;
    end
  end

  always_comb begin
    phase     = PH_IDLE;
    r_nxt     = r;
    cnt_nxt   = cnt;
    out_nxt   = OUT;
    valid_nxt = 1'b0;

    if (cnt < SCR_END)      phase = PH_SCRAMBLE;
    else if (cnt < EXT_END) phase = PH_EXTRACT;

    case (phase)
      PH_SCRAMBLE: begin
        r_nxt   = {^(r & TAPS), r[REG_W-1:1]};
        cnt_nxt = cnt + CNT_W'(1);
      end
      PH_EXTRACT: begin
        out_nxt   = r[0];
        r_nxt     = {1'b0, r[REG_W-1:1]};
        valid_nxt = 1'b1;
        cnt_nxt   = cnt + CNT_W'(1);
      end
      default: begin
`ifdef LFSR_AUTO_RESTART_EN
        r_nxt   = Seed;
        cnt_nxt = '0;
`else
        // counter saturates here; R and OUT hold until the next reset
        cnt_nxt = cnt;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_lfsr.sv
module tb_lfsr;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] seed = 4'd0;
  logic       out;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr #(.LFSR_CYCLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .Seed  (seed),
    .OUT   (out),
    .Valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Register contents after N scramble steps, computed arithmetically:
  // shift right by one, new MSB is the xor of the two low bits.
  function automatic int scrambled(input int s);
    int v = s;
    for (int i = 0; i < N; i++)
      v = (v >> 1) + 8 * (((v >> 1) ^ v) & 1);
    return v;
  endfunction

  // Expected (valid, out) at edge k (k >= 1) after release for a given seed.
  function automatic void expect_at(input int s, input int k,
                                    output int ev, output int eo);
    int b, kk, per;
    b   = scrambled(s);
    kk  = k;
    per = 0;
`ifdef LFSR_AUTO_RESTART_EN
    per = (k - 1) / (N + 5);
    kk  = (k - 1) % (N + 5) + 1;
`endif
    if (kk <= N) begin
      ev = 0;
      eo = (per == 0) ? 0 : (b >> 3) & 1;
    end else if (kk <= N + 4) begin
      ev = 1;
      eo = (b >> (kk - N - 1)) & 1;
    end else begin
      ev = 0;
      eo = (b >> 3) & 1;
    end
  endfunction

  task automatic do_reset(input logic [3:0] s);
    @(negedge clk);
    seed = s;
    rst  = 1'b0;
    #1;
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(valid), 0);
    @(posedge clk);
    #1;
    check("rst_edge_out", int'(out), 0);
    check("rst_edge_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Run n edges after release; optionally wiggle Seed to prove it is ignored.
  task automatic run_seq(input logic [3:0] s, input int n, input bit wiggle);
    int ev, eo;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      expect_at(int'(s), k, ev, eo);
      check("seq_valid", int'(valid), ev);
      check("seq_out", int'(out), eo);
      if (wiggle) seed = 4'($urandom_range(0, 15));
    end
  endtask

  // Hard-coded expectation for the LFSR_CYCLES=8 extraction window.
  task automatic run_directed(input logic [3:0] s, input logic [3:0] bits);
    do_reset(s);
    for (int k = 1; k <= N + 5; k++) begin
      @(posedge clk);
      #1;
      if (k <= N) begin
        check("dir_pre_valid", int'(valid), 0);
        check("dir_pre_out", int'(out), 0);
      end else if (k <= N + 4) begin
        check("dir_valid", int'(valid), 1);
        check("dir_out", int'(out), int'(bits[k-N-1]));
      end else begin
        check("dir_end_valid", int'(valid), 0);
      end
    end
  endtask

  initial begin
    logic [3:0] s;
    int n_run;
`ifdef LFSR_AUTO_RESTART_EN
    n_run = 2 * (N + 5) + 3;
`else
    n_run = N + 8;
`endif

    #1;
    check("init_out", int'(out), 0);
    check("init_valid", int'(valid), 0);

    // bits listed LSB first in index order: bits[0] leaves first
    run_directed(4'b1001, 4'b1111);
    run_directed(4'b0001, 4'b0101);
    run_directed(4'b0000, 4'b0000);

    for (int t = 0; t < 16; t++) begin
      s = 4'($urandom_range(0, 15));
      do_reset(s);
`ifdef LFSR_AUTO_RESTART_EN
      run_seq(s, n_run, 1'b0);
`else
      run_seq(s, n_run, 1'b1);
`endif
    end

    // abort mid-extraction with an asynchronous pulse, then replay
    for (int t = 0; t < 4; t++) begin
      s = 4'($urandom_range(0, 15));
      do_reset(s);
      run_seq(s, N + 2, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("abort_out", int'(out), 0);
      check("abort_valid", int'(valid), 0);
      @(negedge clk);
      rst = 1'b1;
      run_seq(s, n_run, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
